// File: rtl/morra_match_ctrl.sv
// -----------------------------------------------------------------------------
// morra_match_ctrl
//   Match sequencer sitting in front of the rock-paper-scissors game core.
//   Collects one move per player per round, strobes the core with both moves,
//   captures the verdict and reports round / match results. Enforces a per-move
//   timeout (missing moves become 00) and a core response timeout.
//
// Optional feature macro: MORRA_SCORE_EN
//   When defined, adds saturating score counters p1_wins / p2_wins / ties.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start_req           start a new match; aborts a running one
//   p1_vld/p1_move/p1_rdy, p2_vld/p2_move/p2_rdy   move handshakes
//   core_start          one-cycle core clear strobe
//   core_step           one-cycle "play round" strobe
//   core_p1/core_p2     latched moves presented to the core
//   core_res_vld/core_round/core_game   core verdict
//   busy                match in progress
//   round_vld           one-cycle pulse when last_round updates
//   last_round          last captured core_round
//   round_cnt           rounds issued in this match
//   done                one-cycle pulse at match end
//   result              final match result, held until next start_req
//   err                 sticky core-timeout / round-limit flag
//   p1_wins/p2_wins/ties  (MORRA_SCORE_EN only) per-match round tallies
// -----------------------------------------------------------------------------
module morra_match_ctrl #(
  parameter int MOVE_TO    = 64,
  parameter int RESP_TO    = 8,
  parameter int MAX_ROUNDS = 31,
  parameter int ROUND_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_req,
  input  logic               p1_vld,
  input  logic [1:0]         p1_move,
  output logic               p1_rdy,
  input  logic               p2_vld,
  input  logic [1:0]         p2_move,
  output logic               p2_rdy,
  output logic               core_start,
  output logic               core_step,
  output logic [1:0]         core_p1,
  output logic [1:0]         core_p2,
  input  logic               core_res_vld,
  input  logic [1:0]         core_round,
  input  logic [1:0]         core_game,
  output logic               busy,
  output logic               round_vld,
  output logic [1:0]         last_round,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               done,
  output logic [1:0]         result,
`ifdef MORRA_SCORE_EN
  output logic [ROUND_W-1:0] p1_wins,
  output logic [ROUND_W-1:0] p2_wins,
  output logic [ROUND_W-1:0] ties,
`endif
  output logic               err
);

  localparam int MT_W = $clog2(MOVE_TO + 1);
  localparam int RT_W = $clog2(RESP_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_COLLECT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  logic [MT_W-1:0] mv_tmr;
  logic [RT_W-1:0] rsp_tmr;
  logic            p1_rdy_q;
  logic            p2_rdy_q;
  logic            p1_held;
  logic            p2_held;
  logic [1:0]      p1_mv;
  logic [1:0]      p2_mv;

  logic            p1_take;
  logic            p2_take;
  logic            mv_expired;
  logic            p1_got;
  logic            p2_got;
  logic [1:0]      p1_next;
  logic [1:0]      p2_next;

  function automatic logic [ROUND_W-1:0] sat_inc(input logic [ROUND_W-1:0] v);
    return (v == {ROUND_W{1'b1}}) ? v : v + ROUND_W'(1);
  endfunction

  // A start request in the same cycle as a handshake wins: ready is masked
  // so the player does not believe the move was taken.
  assign p1_rdy = p1_rdy_q & ~start_req;
  assign p2_rdy = p2_rdy_q & ~start_req;

  // Move slots hold 00 until a move is taken, so a timeout simply marks the
  // missing slot as held and the null move falls out naturally.
  always_comb begin
    p1_take    = p1_vld & p1_rdy;
    p2_take    = p2_vld & p2_rdy;
    mv_expired = (state == S_COLLECT) && (mv_tmr == '0);
    p1_got     = p1_held | p1_take | mv_expired;
    p2_got     = p2_held | p2_take | mv_expired;
    p1_next    = p1_take ? p1_move : p1_mv;
    p2_next    = p2_take ? p2_move : p2_mv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mv_tmr     <= '0;
      rsp_tmr    <= '0;
      p1_rdy_q   <= 1'b0;
      p2_rdy_q   <= 1'b0;
      p1_held    <= 1'b0;
      p2_held    <= 1'b0;
      p1_mv      <= 2'b00;
      p2_mv      <= 2'b00;
      core_start <= 1'b0;
      core_step  <= 1'b0;
      core_p1    <= 2'b00;
      core_p2    <= 2'b00;
      busy       <= 1'b0;
      round_vld  <= 1'b0;
      last_round <= 2'b00;
      round_cnt  <= '0;
      done       <= 1'b0;
      result     <= 2'b00;
      err        <= 1'b0;
`ifdef MORRA_SCORE_EN
      p1_wins    <= '0;
      p2_wins    <= '0;
      ties       <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      core_step  <= 1'b0;
      round_vld  <= 1'b0;
      done       <= 1'b0;
      if (start_req) begin
        // Start (or abort-and-restart) from any state.
        state      <= S_INIT;
        core_start <= 1'b1;
        busy       <= 1'b1;
        round_cnt  <= '0;
        last_round <= 2'b00;
        result     <= 2'b00;
        err        <= 1'b0;
        p1_rdy_q   <= 1'b0;
        p2_rdy_q   <= 1'b0;
`ifdef MORRA_SCORE_EN
        p1_wins    <= '0;
        p2_wins    <= '0;
        ties       <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_INIT: begin
            state    <= S_COLLECT;
            p1_rdy_q <= 1'b1;
            p2_rdy_q <= 1'b1;
            p1_held  <= 1'b0;
            p2_held  <= 1'b0;
            p1_mv    <= 2'b00;
            p2_mv    <= 2'b00;
            mv_tmr   <= MT_W'(MOVE_TO);
          end
          S_COLLECT: begin
            if (mv_tmr != '0) mv_tmr <= mv_tmr - MT_W'(1);
            p1_held <= p1_got;
            p2_held <= p2_got;
            p1_mv   <= p1_next;
            p2_mv   <= p2_next;
            if (p1_take) p1_rdy_q <= 1'b0;
            if (p2_take) p2_rdy_q <= 1'b0;
            if (p1_got && p2_got) begin
              state     <= S_ISSUE;
              core_step <= 1'b1;
              core_p1   <= p1_next;
              core_p2   <= p2_next;
              round_cnt <= sat_inc(round_cnt);
              p1_rdy_q  <= 1'b0;
              p2_rdy_q  <= 1'b0;
            end
          end
          S_ISSUE: begin
            state   <= S_WAIT;
            rsp_tmr <= RT_W'(RESP_TO);
          end
          S_WAIT: begin
            if (rsp_tmr != '0) rsp_tmr <= rsp_tmr - RT_W'(1);
            // A verdict arriving on the expiry cycle still counts.
            if (core_res_vld) begin
              last_round <= core_round;
              round_vld  <= 1'b1;
`ifdef MORRA_SCORE_EN
              case (core_round)
                2'b01:   p1_wins <= sat_inc(p1_wins);
                2'b10:   p2_wins <= sat_inc(p2_wins);
                2'b11:   ties    <= sat_inc(ties);
                default: ;
              endcase
`endif
              if (core_game != 2'b00) begin
                result <= core_game;
                state  <= S_DONE;
                done   <= 1'b1;
                busy   <= 1'b0;
              end else if (round_cnt == ROUND_W'(MAX_ROUNDS)) begin
                err    <= 1'b1;
                result <= 2'b11;
                state  <= S_DONE;
                done   <= 1'b1;
                busy   <= 1'b0;
              end else begin
                state    <= S_COLLECT;
                p1_rdy_q <= 1'b1;
                p2_rdy_q <= 1'b1;
                p1_held  <= 1'b0;
                p2_held  <= 1'b0;
                p1_mv    <= 2'b00;
                p2_mv    <= 2'b00;
                mv_tmr   <= MT_W'(MOVE_TO);
              end
            end else if (rsp_tmr == '0) begin
              err    <= 1'b1;
              result <= 2'b00;
              state  <= S_DONE;
              done   <= 1'b1;
              busy   <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morra_match_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_morra_match_ctrl
//   Directed bench for morra_match_ctrl. The stimulus side plays both players
//   and the game core; expected core_step / round_vld / done events are queued
//   and a separate monitor pops and compares them as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_morra_match_ctrl;

  localparam int MOVE_TO    = 6;
  localparam int RESP_TO    = 4;
  localparam int MAX_ROUNDS = 4;
  localparam int ROUND_W    = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_req = 1'b0;
  logic               p1_vld = 1'b0;
  logic [1:0]         p1_move = 2'b00;
  logic               p2_vld = 1'b0;
  logic [1:0]         p2_move = 2'b00;
  logic               core_res_vld = 1'b0;
  logic [1:0]         core_round = 2'b00;
  logic [1:0]         core_game = 2'b00;
  logic               p1_rdy, p2_rdy, core_start, core_step;
  logic [1:0]         core_p1, core_p2, last_round, result;
  logic               busy, round_vld, done, err;
  logic [ROUND_W-1:0] round_cnt;
`ifdef MORRA_SCORE_EN
  logic [ROUND_W-1:0] p1_wins, p2_wins, ties;
`endif

  morra_match_ctrl #(
    .MOVE_TO(MOVE_TO), .RESP_TO(RESP_TO), .MAX_ROUNDS(MAX_ROUNDS), .ROUND_W(ROUND_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req),
    .p1_vld(p1_vld), .p1_move(p1_move), .p1_rdy(p1_rdy),
    .p2_vld(p2_vld), .p2_move(p2_move), .p2_rdy(p2_rdy),
    .core_start(core_start), .core_step(core_step),
    .core_p1(core_p1), .core_p2(core_p2),
    .core_res_vld(core_res_vld), .core_round(core_round), .core_game(core_game),
    .busy(busy), .round_vld(round_vld), .last_round(last_round),
    .round_cnt(round_cnt), .done(done), .result(result),
`ifdef MORRA_SCORE_EN
    .p1_wins(p1_wins), .p2_wins(p2_wins), .ties(ties),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 = core_step, 1 = round_vld, 2 = done
  typedef struct {
    int                 kind;
    logic [1:0]         a;
    logic [1:0]         b;
    logic [ROUND_W-1:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass = 0;
  int  n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input int k, input logic [1:0] a, input logic [1:0] b,
                      input logic [ROUND_W-1:0] c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input int kind, input string name, input logic [1:0] a,
                        input logic [1:0] b, input logic [ROUND_W-1:0] cnt);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: got unexpected event, expected none pending", name);
      return;
    end
    e = exp_q.pop_front();
    chk({name, " kind"}, kind, e.kind);
    chk({name, " a"}, a, e.a);
    chk({name, " b"}, b, e.b);
    chk({name, " cnt"}, cnt, e.cnt);
  endtask

  // Monitor: done event carries {busy, err} in field b.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_step) mon_ev(0, "step", core_p1, core_p2, round_cnt);
      if (round_vld) mon_ev(1, "round", last_round, 2'b00, round_cnt);
      if (done)      mon_ev(2, "done", result, {busy, err}, round_cnt);
    end
  end

  task automatic start_match();
    @(negedge clk); start_req = 1'b1;
    @(negedge clk); start_req = 1'b0;
    chk("init core_start", core_start, 1);
    chk("init busy", busy, 1);
    chk("init round_cnt", round_cnt, 0);
    chk("init err", err, 0);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!(p1_rdy && p2_rdy) && n < 20) begin @(negedge clk); n++; end
    if (!(p1_rdy && p2_rdy)) chk("rdy wait expired", 0, 1);
  endtask

  task automatic both_moves(input logic [1:0] m1, input logic [1:0] m2,
                            input logic [ROUND_W-1:0] cnt);
    wait_rdy();
    push(0, m1, m2, cnt);
    p1_vld = 1'b1; p1_move = m1; p2_vld = 1'b1; p2_move = m2;
    @(negedge clk);
    p1_vld = 1'b0; p2_vld = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
    chk("p1_rdy drop", p1_rdy, 0);
    chk("p2_rdy drop", p2_rdy, 0);
    chk("step latency", core_step, 1);
  endtask

  // Called at the negedge of the core_step cycle; answers in WAIT cycle dly+1.
  task automatic reply(input logic [1:0] rnd, input logic [1:0] game, input int dly,
                       input logic [ROUND_W-1:0] cnt, input bit fin,
                       input logic [1:0] fres, input logic ferr);
    repeat (dly + 1) @(negedge clk);
    push(1, rnd, 2'b00, cnt);
    if (fin) push(2, fres, {1'b0, ferr}, cnt);
    core_res_vld = 1'b1; core_round = rnd; core_game = game;
    @(negedge clk);
    core_res_vld = 1'b0; core_round = 2'b00; core_game = 2'b00;
    chk("round_vld latency", round_vld, 1);
    chk("done latency", done, fin);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    // ---- reset values
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst result", result, 0);
    chk("rst round_cnt", round_cnt, 0);
    chk("rst p1_rdy", p1_rdy, 0);
    chk("rst core_step", core_step, 0);
    chk("rst core_start", core_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle p2_rdy", p2_rdy, 0);

    // ---- match 1: simultaneous moves, silent player, core ends on round 3
    start_match();
    both_moves(2'b01, 2'b11, 1);
    reply(2'b01, 2'b00, RESP_TO, 1, 0, 2'b00, 1'b0);  // answer on expiry cycle
    chk("verdict on expiry no err", err, 0);
    chk("verdict on expiry busy", busy, 1);

    wait_rdy();
    push(0, 2'b10, 2'b00, 2);
    p1_vld = 1'b1; p1_move = 2'b10;
    @(negedge clk);
    p1_vld = 1'b0; p1_move = 2'b00;
    chk("p1_rdy after take", p1_rdy, 0);
    chk("p2_rdy still waiting", p2_rdy, 1);
    n = 1;
    while (!core_step && n < 40) begin @(negedge clk); n++; end
    chk("move timeout cycles", n, MOVE_TO + 1);
    reply(2'b00, 2'b00, 0, 2, 0, 2'b00, 1'b0);

    both_moves(2'b11, 2'b10, 3);
    reply(2'b10, 2'b10, 1, 3, 1, 2'b10, 1'b0);
    @(negedge clk);
    chk("after done busy", busy, 0);
    chk("after done result held", result, 2'b10);
    chk("done one cycle", done, 0);

    // ---- match 2: core never answers
    start_match();
    both_moves(2'b01, 2'b01, 1);
    push(2, 2'b00, 2'b01, 1);
    n = 0;
    while (!done && n < 30) begin @(negedge clk); n++; end
    chk("resp timeout cycles", n, RESP_TO + 2);
    @(negedge clk);
    chk("err sticky", err, 1);
    chk("timeout result", result, 2'b00);

    // ---- match 3: abort in WAIT, abort during handshake, round limit
    start_match();
    both_moves(2'b11, 2'b11, 1);
    @(negedge clk);
    start_req = 1'b1;
    core_res_vld = 1'b1; core_round = 2'b01; core_game = 2'b01;
    @(negedge clk);
    start_req = 1'b0;
    chk("abort core_start", core_start, 1);
    chk("abort round_cnt", round_cnt, 0);
    chk("abort err", err, 0);
    chk("abort busy", busy, 1);
    @(negedge clk);
    core_res_vld = 1'b0; core_round = 2'b00; core_game = 2'b00;
    chk("late verdict ignored", last_round, 2'b00);
    p1_vld = 1'b1; p1_move = 2'b10; start_req = 1'b1;
    #1;
    chk("p1_rdy masked by start", p1_rdy, 0);
    chk("p2_rdy masked by start", p2_rdy, 0);
    @(negedge clk);
    p1_vld = 1'b0; p1_move = 2'b00; start_req = 1'b0;
    chk("handshake abort restarts", core_start, 1);

    both_moves(2'b01, 2'b10, 1);
    reply(2'b01, 2'b00, 0, 1, 0, 2'b00, 1'b0);
    both_moves(2'b10, 2'b01, 2);
    reply(2'b10, 2'b00, 2, 2, 0, 2'b00, 1'b0);
    both_moves(2'b11, 2'b11, 3);
    reply(2'b11, 2'b00, 0, 3, 0, 2'b00, 1'b0);
    both_moves(2'b01, 2'b10, 4);
    reply(2'b01, 2'b00, 0, 4, 1, 2'b11, 1'b1);
`ifdef MORRA_SCORE_EN
    chk("p1_wins", p1_wins, 2);
    chk("p2_wins", p2_wins, 1);
    chk("ties", ties, 1);
`endif

    // ---- reset mid-match
    start_match();
    wait_rdy();
    rst_n = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset p1_rdy", p1_rdy, 0);
    chk("midreset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post reset idle busy", busy, 0);
    chk("post reset no step", core_step, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
